// File: rtl/fp_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module  : fp_reg_file_sb
// Brief   : FP register file with NaN-boxing writes, two write ports and a
//           busy-bit scoreboard for long-latency (div/sqrt) destinations.
// Revision: 1.0 - initial release
// ============================================================================
module fp_reg_file_sb #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int BYPASS   = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       freeze,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       w0_en,
    input  logic [ADDR_W-1:0]          w0_addr,
    input  logic [DATA_W-1:0]          w0_data,
    input  logic                       w0_dp,
    input  logic                       w1_valid,
    output logic                       w1_ready,
    input  logic [ADDR_W-1:0]          w1_addr,
    input  logic [DATA_W-1:0]          w1_data,
    input  logic                       w1_dp,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic                       err_waw,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data
);

    // Single-precision values are NaN-boxed: upper bits forced to all ones.
    function automatic logic [DATA_W-1:0] nan_box(input logic [DATA_W-1:0] d,
                                                  input logic              dp);
        return dp ? d : {{(DATA_W-32){1'b1}}, d[31:0]};
    endfunction

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_err;

    logic                w_w0_we;
    logic                w_w1_we;
    logic [DATA_W-1:0]   w_w0_box;
    logic [DATA_W-1:0]   w_w1_box;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_err_dbl;
    logic                w_err_col;
    logic                w_err_w0;

    assign w1_ready = ~freeze;
    assign w_w0_we  = w0_en & ~freeze;
    assign w_w1_we  = w1_valid & w1_ready;
    assign w_w0_box = nan_box(w0_data, w0_dp);
    assign w_w1_box = nan_box(w1_data, w1_dp);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_set[r] = sb_set_en & ~freeze & (sb_set_addr == ADDR_W'(r));
            w_clr[r] = w_w1_we & (w1_addr == ADDR_W'(r));
        end
    end

    // Set beats a same-cycle clear so a destination can be reissued back-to-back.
    assign w_busy_nxt = w_set | (r_busy & ~w_clr);
    assign w_err_dbl  = |(w_set & r_busy & ~w_clr);
    assign w_err_col  = w_w0_we & w_w1_we & (w0_addr == w1_addr);
    assign w_err_w0   = w_w0_we & r_busy[w0_addr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            // W0 is written last so it wins an address collision.
            if (w_w1_we) begin
                r_regs[w1_addr] <= w_w1_box;
            end
            if (w_w0_we) begin
                r_regs[w0_addr] <= w_w0_box;
            end
            r_busy <= w_busy_nxt;
            if (w_err_dbl | w_err_col | w_err_w0) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_vec = r_busy;
    assign err_waw  = r_err;
    assign dbg_data = r_regs[dbg_addr];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

        if (BYPASS != 0) begin : g_byp
            assign rd_data[i*DATA_W +: DATA_W] =
                (w_w0_we && (w0_addr == w_addr)) ? w_w0_box :
                (w_w1_we && (w1_addr == w_addr)) ? w_w1_box :
                                                   r_regs[w_addr];
            assign rd_busy[i] = r_busy[w_addr] & ~(w_w1_we & (w1_addr == w_addr));
        end else begin : g_nobyp
            assign rd_data[i*DATA_W +: DATA_W] = r_regs[w_addr];
            assign rd_busy[i] = r_busy[w_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_reg_file_sb
// Brief   : Directed vector bench for fp_reg_file_sb, bypassed and unbypassed.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_reg_file_sb;

    localparam logic        N  = 1'b0;
    localparam logic        Y  = 1'b1;
    localparam logic [63:0] Z  = 64'd0;
    localparam logic [63:0] A  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] AS = 64'hFFFF_FFFF_9ABC_DEF0;
    localparam logic [63:0] B  = 64'h40FE_2400_0000_0000;
    localparam logic [63:0] C  = 64'hC0E6_4DC0_0000_0000;
    localparam logic [63:0] D  = 64'hFFFF_FFFF_0000_0000;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         freeze = 1'b0;
    logic [14:0]  rd_addr = '0;
    logic         w0_en = 1'b0;
    logic [4:0]   w0_addr = '0;
    logic [63:0]  w0_data = '0;
    logic         w0_dp = 1'b0;
    logic         w1_valid = 1'b0;
    logic [4:0]   w1_addr = '0;
    logic [63:0]  w1_data = '0;
    logic         w1_dp = 1'b0;
    logic         sb_set_en = 1'b0;
    logic [4:0]   sb_set_addr = '0;
    logic [4:0]   dbg_addr = '0;

    logic [191:0] rd_data_b, rd_data_n;
    logic [2:0]   rd_busy_b, rd_busy_n;
    logic         w1_ready_b, w1_ready_n;
    logic [31:0]  busy_vec_b, busy_vec_n;
    logic         err_b, err_n;
    logic [63:0]  dbg_b, dbg_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fp_reg_file_sb #(.BYPASS(1)) dut (
        .CLK(CLK), .RST(RST), .freeze(freeze),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data), .w0_dp(w0_dp),
        .w1_valid(w1_valid), .w1_ready(w1_ready_b), .w1_addr(w1_addr),
        .w1_data(w1_data), .w1_dp(w1_dp),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(busy_vec_b), .err_waw(err_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    fp_reg_file_sb #(.BYPASS(0)) dut_nb (
        .CLK(CLK), .RST(RST), .freeze(freeze),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data), .w0_dp(w0_dp),
        .w1_valid(w1_valid), .w1_ready(w1_ready_n), .w1_addr(w1_addr),
        .w1_data(w1_data), .w1_dp(w1_dp),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(busy_vec_n), .err_waw(err_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_n)
    );

    typedef struct {
        logic        fz;
        logic        w0e;  logic [4:0] w0a;  logic [63:0] w0d;  logic w0p;
        logic        w1v;  logic [4:0] w1a;  logic [63:0] w1d;  logic w1p;
        logic        sbe;  logic [4:0] sba;
        logic [4:0]  ra;
        logic [63:0] e_rd_b;  logic [63:0] e_rd_n;
        logic        e_bsy_b; logic        e_bsy_n;
        logic        e_err;   logic        e_rdy;
    } vec_t;

    vec_t tv [20];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        freeze = 1'b0; w0_en = 1'b0; w1_valid = 1'b0; sb_set_en = 1'b0;
        w0_dp = 1'b0; w1_dp = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr  = {3{5'(a)}};
            dbg_addr = 5'(a);
            #1;
            chk({tag, " rd_data bypass"}, rd_data_b, '0);
            chk({tag, " rd_data nobypass"}, rd_data_n, '0);
            chk({tag, " rd_busy"}, {rd_busy_b, rd_busy_n}, '0);
            chk({tag, " dbg_data"}, {dbg_b, dbg_n}, '0);
        end
        chk({tag, " busy_vec"}, {busy_vec_b, busy_vec_n}, '0);
        chk({tag, " err_waw"}, {err_b, err_n}, '0);
    endtask

    initial begin
        tv[0]  = '{N, Y,5'd3,A,N,   N,5'd0,Z,N,  N,5'd0,  5'd3,  AS,Z,  N,N, N,Y};
        tv[1]  = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd3,  AS,AS, N,N, N,Y};
        tv[2]  = '{N, Y,5'd3,A,Y,   N,5'd0,Z,N,  N,5'd0,  5'd3,  A,AS,  N,N, N,Y};
        tv[3]  = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd3,  A,A,   N,N, N,Y};
        tv[4]  = '{N, Y,5'd7,B,Y,   N,5'd0,Z,N,  N,5'd0,  5'd7,  B,Z,   N,N, N,Y};
        tv[5]  = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd7,  B,B,   N,N, N,Y};
        tv[6]  = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  Y,5'd12, 5'd12, Z,Z,   N,N, N,Y};
        tv[7]  = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd12, Z,Z,   Y,Y, N,Y};
        tv[8]  = '{N, N,5'd0,Z,N,   Y,5'd12,C,Y, N,5'd0,  5'd12, C,Z,   N,Y, N,Y};
        tv[9]  = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd12, C,C,   N,N, N,Y};
        tv[10] = '{Y, Y,5'd5,A,Y,   Y,5'd5,B,Y,  Y,5'd5,  5'd5,  Z,Z,   N,N, N,N};
        tv[11] = '{N, N,5'd0,Z,N,   Y,5'd5,B,Y,  N,5'd0,  5'd5,  B,Z,   N,N, N,Y};
        tv[12] = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd5,  B,B,   N,N, N,Y};
        tv[13] = '{N, N,5'd0,Z,N,   Y,5'd20,C,N, N,5'd0,  5'd20, D,Z,   N,N, N,Y};
        tv[14] = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd20, D,D,   N,N, N,Y};
        tv[15] = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  Y,5'd30, 5'd30, Z,Z,   N,N, N,Y};
        tv[16] = '{N, N,5'd0,Z,N,   Y,5'd30,B,Y, Y,5'd30, 5'd30, B,Z,   N,Y, N,Y};
        tv[17] = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd30, B,B,   Y,Y, N,Y};
        tv[18] = '{N, Y,5'd22,A,Y,  Y,5'd22,C,Y, N,5'd0,  5'd22, A,Z,   N,N, N,Y};
        tv[19] = '{N, N,5'd0,Z,N,   N,5'd0,Z,N,  N,5'd0,  5'd22, A,A,   N,N, Y,Y};

        do_reset();
        sweep_zero("reset");

        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            freeze = tv[k].fz;
            w0_en = tv[k].w0e; w0_addr = tv[k].w0a; w0_data = tv[k].w0d; w0_dp = tv[k].w0p;
            w1_valid = tv[k].w1v; w1_addr = tv[k].w1a; w1_data = tv[k].w1d; w1_dp = tv[k].w1p;
            sb_set_en = tv[k].sbe; sb_set_addr = tv[k].sba;
            rd_addr = {10'd0, tv[k].ra};
            #1;
            chk($sformatf("v%0d rd_data bypass", k), {128'd0, rd_data_b[63:0]}, {128'd0, tv[k].e_rd_b});
            chk($sformatf("v%0d rd_data nobypass", k), {128'd0, rd_data_n[63:0]}, {128'd0, tv[k].e_rd_n});
            chk($sformatf("v%0d rd_busy bypass", k), {191'd0, rd_busy_b[0]}, {191'd0, tv[k].e_bsy_b});
            chk($sformatf("v%0d rd_busy nobypass", k), {191'd0, rd_busy_n[0]}, {191'd0, tv[k].e_bsy_n});
            chk($sformatf("v%0d err_waw", k), {190'd0, err_b, err_n}, {190'd0, tv[k].e_err, tv[k].e_err});
            chk($sformatf("v%0d w1_ready", k), {190'd0, w1_ready_b, w1_ready_n}, {190'd0, tv[k].e_rdy, tv[k].e_rdy});
        end

        // Remaining state after the table: other read ports, debug port, scoreboard.
        @(negedge CLK);
        idle();
        rd_addr = {5'd7, 5'd3, 5'd0};
        dbg_addr = 5'd12;
        #1;
        chk("port1 reg3", {128'd0, rd_data_b[127:64]}, {128'd0, A});
        chk("port2 reg7", {128'd0, rd_data_n[191:128]}, {128'd0, B});
        chk("dbg reg12", {128'd0, dbg_b, dbg_n}, {128'd0, C, C});
        dbg_addr = 5'd22;
        #1;
        chk("dbg reg22 collision", {128'd0, dbg_b, dbg_n}, {128'd0, A, A});
        dbg_addr = 5'd5;
        #1;
        chk("dbg reg5 after freeze", {128'd0, dbg_b, dbg_n}, {128'd0, B, B});
        chk("busy_vec after table", {128'd0, busy_vec_b, busy_vec_n}, {128'd0, 32'h4000_0000, 32'h4000_0000});
        repeat (3) @(negedge CLK);
        #1;
        chk("err sticky", {190'd0, err_b, err_n}, {190'd0, 2'b11});

        do_reset();
        sweep_zero("re-reset");

        // Double issue to the same destination without an intervening clear.
        @(negedge CLK);
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        @(negedge CLK);
        #1;
        chk("dbl first set err", {190'd0, err_b, err_n}, '0);
        chk("dbl busy_vec", {128'd0, busy_vec_b, busy_vec_n}, {128'd0, 32'h200, 32'h200});
        @(negedge CLK);
        idle();
        #1;
        chk("dbl second set err", {190'd0, err_b, err_n}, {190'd0, 2'b11});

        do_reset();
        chk("reset clears err", {190'd0, err_b, err_n}, '0);

        // W0 writeback to a register still owned by an in-flight long op.
        @(negedge CLK);
        sb_set_en = 1'b1; sb_set_addr = 5'd4;
        @(negedge CLK);
        idle();
        w0_en = 1'b1; w0_addr = 5'd4; w0_data = B; w0_dp = 1'b1;
        #1;
        chk("w0busy err before", {190'd0, err_b, err_n}, '0);
        @(negedge CLK);
        idle();
        dbg_addr = 5'd4;
        #1;
        chk("w0busy err after", {190'd0, err_b, err_n}, {190'd0, 2'b11});
        chk("w0busy reg written", {128'd0, dbg_b, dbg_n}, {128'd0, B, B});
        chk("w0busy busy kept", {128'd0, busy_vec_b, busy_vec_n}, {128'd0, 32'h10, 32'h10});

        do_reset();
        chk("final err", {190'd0, err_b, err_n}, '0);
        chk("final busy_vec", {128'd0, busy_vec_b, busy_vec_n}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
